axi_lite_rr_arbiter: RTL
========================

Name: axi_lite_rr_arbiter

Overview:
- Round-robin scheduler that shares one AXI4-Lite master port between NUM_REQ independent command requesters, such as test sequencers, DMA stubs or config engines.
- Each requester issues single read/write commands over a valid/ready command channel and receives a one-cycle response pulse.
- The block owns the full AR/R/AW/W/B sequencing and keeps exactly one transaction outstanding on the bus.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of the grant index.

Ports:
- aclk  input  1  bus clock.
- areset_n  input  1  reset; one clock; reset is asynchronous and active-low.
- m_axi_lite  interface  axi_lite_if.master  shared AXI4-Lite master port: AR, R (rdata, rresp), AW, W (wdata, wstrb), B (bresp).
- req_valid  input  NUM_REQ  per-requester command valid.
- req_ready  output  NUM_REQ  one-hot acceptance pulse.
- req_write  input  NUM_REQ  1 = write, 0 = read.
- req_addr  input  NUM_REQ x addr_t  command address.
- req_wdata  input  NUM_REQ x data_t  write data.
- req_wstrb  input  NUM_REQ x 4  write strobes.
- rsp_valid  output  NUM_REQ  one-hot, one-cycle completion pulse.
- rsp_rdata  output  data_t  read data; 0 for writes.
- rsp_resp  output  2  rresp or bresp of the completed transaction.
- busy  output  1  high whenever state != IDLE.
- grant_id  output  ID_W  index of the current or last granted requester.

Behaviour:
- Reset (async assert, sync deassert on aclk):
  - state = IDLE; all valid/ready outputs = 0; araddr/awaddr/wdata/wstrb = 0.
  - rsp_rdata = 0; rsp_resp = 0; grant_id = 0.
  - rr_ptr = NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, RADDR, RDATA, WADDR, WRESP, RESP.
- IDLE:
  - If any req_valid is set, select g = first set bit searching from rr_ptr+1 upward, modulo NUM_REQ.
  - In the same cycle, assert req_ready[g] (combinational, one-hot) and latch addr/wdata/wstrb/write.
  - Update rr_ptr = g and grant_id = g.
  - Next state: WADDR if write, else RADDR.
  - No req_ready is asserted outside IDLE.
- RADDR:
  - arvalid = 1, araddr = latched addr.
  - On arready go to RDATA.
- RDATA:
  - rready = 1.
  - On rvalid, capture rdata and rresp, then go to RESP.
- WADDR:
  - awvalid and wvalid rise together in the first WADDR cycle.
  - Each drops individually after its own handshake; done flags aw_done and w_done track this.
  - Go to WRESP in the cycle after both are done. Simultaneous AW and W acceptance is legal and costs one cycle.
  - wstrb = latched value while wvalid is high, else 0.
- WRESP:
  - bready = 1.
  - On bvalid, capture bresp, set rsp_rdata = 0, go to RESP.
- RESP:
  - rsp_valid[grant_id] = 1 for exactly one cycle; rsp_rdata and rsp_resp are held valid until the next RESP.
  - Then go to IDLE.
- Arbitration rules:
  - Minimum gap between grants is one IDLE cycle.
  - A requester that stays valid is served within NUM_REQ transactions (no starvation).
  - Requesters must hold req_* stable until req_ready is seen; requests withdrawn before grant are legal and ignored.
- Address/data output drive: araddr, awaddr and wdata are 0 whenever the corresponding valid is 0.
- Latency with a zero-wait slave: read grant to rsp_valid = 3 cycles; write grant to rsp_valid = 3 cycles.
- Bus stalls: the block never times out or abandons a transaction. It waits indefinitely and AXI valids stay stable while waiting.
- Reset mid-transaction: all bus valids drop immediately and no rsp_valid is issued. A command in flight is lost, and the requester must re-issue it.
- A response of SLVERR/DECERR is passed through unchanged on rsp_resp; no retry.

Decomposition:
- axi_lite_pkg additions:
  - arb_state_t enum.
  - resp_t (logic [1:0]) with constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - Reuse the existing addr_t and data_t.
- Sub-module rr_arbiter: pure round-robin picker.
  - Inputs: req vector, rr_ptr, enable.
  - Outputs: grant one-hot, grant_idx, any_grant.
  - Verified standalone.

Test Plan:
- Single read: req_valid=4'b0001, addr=32'h4; slave returns rdata=32'hece00593, rresp=0 -> rsp_valid[0] for one cycle, rsp_rdata=32'hece00593, rsp_resp=0, 3 cycles after req_ready.
- Single write: requester 2 writes 32'hdeadbeef to 32'h10 with wstrb=4'hf; slave accepts W one cycle before AW -> awvalid and wvalid each drop after their own handshake, bready follows, rsp_valid[2] with rsp_resp=0.
- Fairness: all four requesters held valid continuously -> grant order 0,1,2,3,0,1, and no requester is granted twice within 4 grants.
- Backpressure: arready held low for 10 cycles -> arvalid=1 and araddr stable throughout, req_ready=0 for all requesters, busy=1.
- Error passthrough: slave returns bresp=2'b10 on requester 3's write -> rsp_resp=2'b10 and rsp_valid[3] pulses once.
- Reset mid-RDATA: assert areset_n=0 while rready=1 -> rready, arvalid and rsp_valid go to 0 asynchronously; after release the next grant goes to requester 0.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_pkg
// Shared AXI4-Lite types plus the arbiter FSM state and response encodings.
//   addr_t / data_t / strb_t : bus field types
//   resp_t + RESP_*          : xRESP encodings
//   arb_state_t              : sequencing states of axi_lite_rr_arbiter
// ---------------------------------------------------------------------------
package axi_lite_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [STRB_W-1:0] strb_t;

  typedef logic [1:0] resp_t;
  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ARB_IDLE  = 3'd0,
    ARB_RADDR = 3'd1,
    ARB_RDATA = 3'd2,
    ARB_WADDR = 3'd3,
    ARB_WRESP = 3'd4,
    ARB_RESP  = 3'd5
  } arb_state_t;

endpackage

// File: rtl/axi_lite_if.sv
// ---------------------------------------------------------------------------
// axi_lite_if
// AXI4-Lite signal bundle (no prot/cache sidebands).
//   master modport : drives AR/AW/W valids+payload, rready, bready
//   slave  modport : mirror image
// ---------------------------------------------------------------------------
interface axi_lite_if;
  import axi_lite_pkg::*;

  addr_t araddr;
  logic  arvalid;
  logic  arready;
  data_t rdata;
  resp_t rresp;
  logic  rvalid;
  logic  rready;
  addr_t awaddr;
  logic  awvalid;
  logic  awready;
  data_t wdata;
  strb_t wstrb;
  logic  wvalid;
  logic  wready;
  resp_t bresp;
  logic  bvalid;
  logic  bready;

  modport master (
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready,
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready
  );

  modport slave (
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready
  );

endinterface

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Pure combinational round-robin picker. Searches req starting at
// rr_ptr+1 (wrapping modulo NUM_REQ) and grants the first set bit.
//   req       : request vector
//   rr_ptr    : index of the last granted requester
//   enable    : gates all grant outputs
//   grant     : one-hot grant
//   grant_idx : index of the winner (valid when any_grant)
//   any_grant : a winner exists and enable is high
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_grant
);

  logic [ID_W-1:0] cand_s;
  logic [ID_W-1:0] idx_s;
  logic            found_s;

  // Rotating priority search; the first hit after rr_ptr wins.
  always_comb begin
    cand_s  = '0;
    idx_s   = '0;
    found_s = 1'b0;
    grant   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found_s && req[cand_s]) begin
        found_s = 1'b1;
        idx_s   = cand_s;
      end else begin
        found_s = found_s;
      end
    end
    any_grant = found_s & enable;
    grant_idx = idx_s;
    if (any_grant) begin
      grant[idx_s] = 1'b1;
    end else begin
      grant = '0;
    end
  end

endmodule

// File: rtl/axi_lite_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axi_lite_rr_arbiter
// Shares one AXI4-Lite master port among NUM_REQ command requesters with
// round-robin arbitration; exactly one bus transaction is outstanding.
//   aclk, areset_n          : clock, async active-low reset
//   m_axi_lite              : shared AXI4-Lite master port
//   req_valid/ready         : per-requester command handshake (ready one-hot)
//   req_write/addr/wdata/wstrb : command payload
//   rsp_valid               : one-hot, one-cycle completion pulse
//   rsp_rdata / rsp_resp    : read data (0 for writes) and xRESP
//   busy                    : transaction in progress
//   grant_id                : current or last granted requester
// ---------------------------------------------------------------------------
module axi_lite_rr_arbiter
  import axi_lite_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                          aclk,
  input  logic                          areset_n,
  axi_lite_if.master                    m_axi_lite,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_write,
  input  addr_t [NUM_REQ-1:0]           req_addr,
  input  data_t [NUM_REQ-1:0]           req_wdata,
  input  logic [NUM_REQ-1:0][STRB_W-1:0] req_wstrb,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output data_t                         rsp_rdata,
  output resp_t                         rsp_resp,
  output logic                          busy,
  output logic [ID_W-1:0]               grant_id
);

  arb_state_t           state_r;
  logic [ID_W-1:0]      rr_ptr_r;
  logic [ID_W-1:0]      grant_id_r;
  logic                 busy_r;
  logic [NUM_REQ-1:0]   rsp_valid_r;
  data_t                rsp_rdata_r;
  resp_t                rsp_resp_r;
  addr_t                araddr_r;
  logic                 arvalid_r;
  logic                 rready_r;
  addr_t                awaddr_r;
  logic                 awvalid_r;
  data_t                wdata_r;
  strb_t                wstrb_r;
  logic                 wvalid_r;
  logic                 bready_r;
  logic                 aw_done_r;
  logic                 w_done_r;

  logic [NUM_REQ-1:0]   grant_s;
  logic [ID_W-1:0]      grant_idx_s;
  logic                 any_grant_s;
  logic                 aw_hs_s;
  logic                 w_hs_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_r),
    .enable    (state_r == ARB_IDLE),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .any_grant (any_grant_s)
  );

  assign aw_hs_s = awvalid_r & m_axi_lite.awready;
  assign w_hs_s  = wvalid_r & m_axi_lite.wready;

  // Sequencer: grant, drive one AXI transaction, pulse the response.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_r     <= ARB_IDLE;
      rr_ptr_r    <= ID_W'(NUM_REQ - 1);
      grant_id_r  <= '0;
      busy_r      <= 1'b0;
      rsp_valid_r <= '0;
      rsp_rdata_r <= '0;
      rsp_resp_r  <= RESP_OKAY;
      araddr_r    <= '0;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
      awaddr_r    <= '0;
      awvalid_r   <= 1'b0;
      wdata_r     <= '0;
      wstrb_r     <= '0;
      wvalid_r    <= 1'b0;
      bready_r    <= 1'b0;
      aw_done_r   <= 1'b0;
      w_done_r    <= 1'b0;
    end else begin
      rsp_valid_r <= '0;
      case (state_r)
        ARB_IDLE: begin
          if (any_grant_s) begin
            rr_ptr_r   <= grant_idx_s;
            grant_id_r <= grant_idx_s;
            busy_r     <= 1'b1;
            if (req_write[grant_idx_s]) begin
              state_r   <= ARB_WADDR;
              awvalid_r <= 1'b1;
              awaddr_r  <= req_addr[grant_idx_s];
              wvalid_r  <= 1'b1;
              wdata_r   <= req_wdata[grant_idx_s];
              wstrb_r   <= req_wstrb[grant_idx_s];
              aw_done_r <= 1'b0;
              w_done_r  <= 1'b0;
            end else begin
              state_r   <= ARB_RADDR;
              arvalid_r <= 1'b1;
              araddr_r  <= req_addr[grant_idx_s];
            end
          end
        end
        ARB_RADDR: begin
          if (m_axi_lite.arready) begin
            arvalid_r <= 1'b0;
            araddr_r  <= '0;
            rready_r  <= 1'b1;
            state_r   <= ARB_RDATA;
          end
        end
        ARB_RDATA: begin
          if (m_axi_lite.rvalid) begin
            rready_r                <= 1'b0;
            rsp_rdata_r             <= m_axi_lite.rdata;
            rsp_resp_r              <= m_axi_lite.rresp;
            rsp_valid_r[grant_id_r] <= 1'b1;
            state_r                 <= ARB_RESP;
          end
        end
        ARB_WADDR: begin
          // AW and W retire independently; payload is zeroed once accepted.
          if (aw_hs_s) begin
            awvalid_r <= 1'b0;
            awaddr_r  <= '0;
            aw_done_r <= 1'b1;
          end
          if (w_hs_s) begin
            wvalid_r <= 1'b0;
            wdata_r  <= '0;
            wstrb_r  <= '0;
            w_done_r <= 1'b1;
          end
          if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) begin
            bready_r <= 1'b1;
            state_r  <= ARB_WRESP;
          end
        end
        ARB_WRESP: begin
          if (m_axi_lite.bvalid) begin
            bready_r                <= 1'b0;
            rsp_rdata_r             <= '0;
            rsp_resp_r              <= m_axi_lite.bresp;
            rsp_valid_r[grant_id_r] <= 1'b1;
            state_r                 <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          busy_r  <= 1'b0;
          state_r <= ARB_IDLE;
        end
        default: begin
          arvalid_r <= 1'b0;
          rready_r  <= 1'b0;
          awvalid_r <= 1'b0;
          wvalid_r  <= 1'b0;
          bready_r  <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= ARB_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = grant_s;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_rdata  = rsp_rdata_r;
  assign rsp_resp   = rsp_resp_r;
  assign busy       = busy_r;
  assign grant_id   = grant_id_r;

  assign m_axi_lite.araddr  = araddr_r;
  assign m_axi_lite.arvalid = arvalid_r;
  assign m_axi_lite.rready  = rready_r;
  assign m_axi_lite.awaddr  = awaddr_r;
  assign m_axi_lite.awvalid = awvalid_r;
  assign m_axi_lite.wdata   = wdata_r;
  assign m_axi_lite.wstrb   = wstrb_r;
  assign m_axi_lite.wvalid  = wvalid_r;
  assign m_axi_lite.bready  = bready_r;

endmodule
